twos_comp_accum: RTL
====================

// Module: twos_comp_accum
// PURPOSE
//  Downstream consumer of the 12-bit two's-complement (negated) word from the
//  complement stage. Sums COUNT consecutive signed samples using a valid/ready
//  handshake, then presents one saturated signed 12-bit result.
//  Sits between the complement stage and the result register/readout.
// PARAMETERS
//  WIDTH      12  sample and result width (two's complement)
//  COUNT      4   samples summed per result (>=1)
//  ACC_WIDTH  16  internal accumulator width; must be >= WIDTH+clog2(COUNT)
// PORTS
//  t_clk     in   1      single clock, all state updates on rising edge
//  rst_n     in   1      synchronous reset, active low
//  clear     in   1      synchronous abort of the current block
//  in_valid  in   1      in_data holds a valid sample
//  in_ready  out  1      block accepts a sample this cycle
//  in_data   in   WIDTH  signed sample from the complement stage
//  out_valid out  1      out_data/out_sat hold a valid result
//  out_ready in   1      consumer accepts the result this cycle
//  out_data  out  WIDTH  saturated signed sum
//  out_sat   out  1      1 = the sum was clipped to a WIDTH-bit limit
//  busy      out  1      1 while in ACCUM or HOLD
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=IDLE, acc=0, cnt=0, out_valid=0,
//   out_data=0, out_sat=0, in_ready=1, busy=0. Reset beats every other input.
//  Transfer: in_valid&in_ready (input); out_valid&out_ready (output).
//  in_ready = (state!=HOLD). Decoded from registered state only; there is no
//   combinational path from out_ready or in_valid to in_ready.
//  FSM:
//   IDLE : on input transfer acc<=sext(in_data), cnt<=1;
//          go to HOLD if COUNT==1, otherwise to ACCUM.
//   ACCUM: on input transfer acc<=acc+sext(in_data), cnt<=cnt+1;
//          go to HOLD when the transfer is sample number COUNT.
//   HOLD : out_valid=1; out_data and out_sat are registered on entry and stay
//          stable until the output transfer; then go to IDLE, acc<=0, cnt<=0.
//  Latency: out_valid rises on the first edge after the COUNT-th input transfer.
//  Throughput: no input is accepted in HOLD, so a block takes at least
//   COUNT+1 cycles.
//  Saturation: acc>2^(WIDTH-1)-1 gives out_data=0x7FF, out_sat=1;
//   acc<-2^(WIDTH-1) gives out_data=0x800, out_sat=1;
//   otherwise out_data=acc[WIDTH-1:0], out_sat=0. The accumulator never wraps.
//  clear=1 at an edge: state=IDLE, acc=0, cnt=0, out_valid=0. Any input or
//   output transfer in the same cycle is discarded. Priority: reset, then
//   clear, then the handshakes.
//  Idle stalls (in_valid=0) leave acc and cnt unchanged in any state.
//  out_data and out_sat are don't-care while out_valid=0, but are held at
//   their last registered values.
// TESTING
//  1. Reset, 4 samples of 0x001 with out_ready=1 -> out_data=0x004,
//     out_sat=0, out_valid high exactly 1 cycle.
//  2. Samples 0x005,0xFFB,0x003,0xFFE -> out_data=0x001, out_sat=0.
//  3. 4 samples of 0x7FF -> out_data=0x7FF, out_sat=1;
//     4 samples of 0x800 -> out_data=0x800, out_sat=1.
//  4. Backpressure: out_ready=0 for 5 cycles in HOLD -> out_data stable,
//     in_ready=0, offered inputs not consumed; release -> IDLE the next cycle.
//  5. clear after 2 accepted samples, then 4 samples of 0x001 -> 0x004.
//     clear during HOLD -> out_valid drops and no result is delivered.
//  6. rst_n=0 for 1 cycle mid-ACCUM -> all outputs at reset values; the next
//     4 samples of 0x002 -> 0x008. Randomized in_valid gaps give an unchanged
//     sum.

Source files
------------

// File: rtl/twos_comp_accum.sv
// twos_comp_accum
// Sums COUNT consecutive signed samples from the complement stage over a
// valid/ready handshake and presents one saturated signed WIDTH-bit result.
// The accumulator is wide enough that it never wraps; clipping is applied
// only when the result is registered on entry to HOLD.
module twos_comp_accum #(
    parameter int unsigned WIDTH     = 12,
    parameter int unsigned COUNT     = 4,
    parameter int unsigned ACC_WIDTH = 16
) (
    input  logic             t_clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sat,
    output logic             busy
);

    localparam int unsigned CNT_W = (COUNT < 2) ? 1 : $clog2(COUNT + 1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        ACC_WIDTH'($signed({1'b0, {(WIDTH-1){1'b1}}}));
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        ACC_WIDTH'($signed({1'b1, {(WIDTH-1){1'b0}}}));

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t                        state_q, state_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic        [CNT_W-1:0]       cnt_q, cnt_d;
    logic        [WIDTH-1:0]       out_data_q, out_data_d;
    logic                          out_sat_q, out_sat_d;

    logic signed [ACC_WIDTH-1:0]   sample_sext;
    logic signed [ACC_WIDTH-1:0]   sum;
    logic                          in_xfer;
    logic        [WIDTH-1:0]       sat_data;
    logic                          sat_flag;

    // State register: reset first, everything else decided in the next-state logic.
    always_ff @(posedge t_clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

    // Running sum including the current sample, and its clipped WIDTH-bit form.
    always_comb begin
        sample_sext = ACC_WIDTH'($signed(in_data));
        sum         = (state_q == IDLE) ? sample_sext : (acc_q + sample_sext);
        in_xfer     = in_valid && (state_q != HOLD);
        if (sum > SAT_MAX) begin
            sat_data = SAT_MAX[WIDTH-1:0];
            sat_flag = 1'b1;
        end else if (sum < SAT_MIN) begin
            sat_data = SAT_MIN[WIDTH-1:0];
            sat_flag = 1'b1;
        end else begin
            sat_data = sum[WIDTH-1:0];
            sat_flag = 1'b0;
        end
    end

    // Next-state and datapath: clear overrides both handshakes.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_xfer) begin
                        acc_d = sum;
                        cnt_d = CNT_ONE;
                        if (COUNT == 1) begin
                            state_d    = HOLD;
                            out_data_d = sat_data;
                            out_sat_d  = sat_flag;
                        end else begin
                            state_d = ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (in_xfer) begin
                        acc_d = sum;
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_q == CNT_LAST) begin
                            state_d    = HOLD;
                            out_data_d = sat_data;
                            out_sat_d  = sat_flag;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        in_ready  = (state_q != HOLD);
        out_valid = (state_q == HOLD);
        busy      = (state_q != IDLE);
        out_data  = out_data_q;
        out_sat   = out_sat_q;
    end

endmodule
